y_capture_fifo: RTL and testbench

//   Downstream capture stage for the 4-bit mux output Y of the generate_if datapath.
//   - Samples Y on qualified cycles into a DEPTH-entry first-word-fall-through FIFO.
//   - Presents the stored words to the next consumer over a valid/ready handshake.
//   - Flags and counts words lost on overflow; the mux has no backpressure.

---
 rtl/y_capture_fifo.sv | 98 +++++++++
 tb/tb_y_capture_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/y_capture_fifo.sv
// y_capture_fifo: capture qualified mux Y words into a first-word-fall-through FIFO with a valid/ready output
//   Ports: clk, rst_n (async, active low), clear (sync flush),
//          in_valid/in_data/in_ready (capture side, no backpressure upstream),
//          out_valid/out_data/out_ready (consumer side, FWFT head),
//          count/full/empty (occupancy), overflow (sticky drop flag).
//   Optional: define CAPTURE_STATS_EN to add saturating accepted_cnt/dropped_cnt outputs.
module y_capture_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
`ifdef CAPTURE_STATS_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
`ifdef CAPTURE_STATS_EN
    , output logic [CNT_W-1:0]       accepted_cnt,
    output logic [CNT_W-1:0]         dropped_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic             drop;

    // Status comes only from the registered count, never from the handshake inputs.
    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    // Clear suppresses both sides; a full FIFO drops the incoming word even when the head pops.
    assign wr_en = !clear && in_valid && !full;
    assign drop  = !clear && in_valid && full;
    assign rd_en = !clear && out_ready && !empty;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
            if (drop)
                overflow <= 1'b1;
        end
    end

`ifdef CAPTURE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accepted_cnt <= '0;
            dropped_cnt  <= '0;
        end else if (clear) begin
            accepted_cnt <= '0;
            dropped_cnt  <= '0;
        end else begin
            if (wr_en && accepted_cnt != '1)
                accepted_cnt <= accepted_cnt + CNT_W'(1);
            if (drop && dropped_cnt != '1)
                dropped_cnt <= dropped_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_y_capture_fifo.sv
// tb_y_capture_fifo: randomized and directed scoreboard bench for y_capture_fifo
module tb_y_capture_fifo;
    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int CNT_MAX = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [3:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;
`ifdef CAPTURE_STATS_EN
    logic [7:0]       accepted_cnt;
    logic [7:0]       dropped_cnt;
`endif

    y_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
`ifdef CAPTURE_STATS_EN
        , .accepted_cnt(accepted_cnt), .dropped_cnt(dropped_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    // Reference model: FIFO contents as a queue of expected words, plus occupancy and flags.
    logic [WIDTH-1:0] exp_q[$];
    int mcnt = 0;
    int movf = 0;
    int macc = 0;
    int mdrp = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mcnt = 0;
        movf = 0;
        macc = 0;
        mdrp = 0;
    endtask

    // One clock of stimulus; the model decides accept/drop/pop from pre-edge occupancy.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
        bit acc, pop, drp;
        in_valid = v;
        in_data = d;
        out_ready = r;
        clear = c;
        acc = !c && v && mcnt < DEPTH;
        drp = !c && v && mcnt == DEPTH;
        pop = !c && r && mcnt > 0;
        if (acc)
            exp_q.push_back(d);
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            mcnt = mcnt + int'(acc) - int'(pop);
            if (drp) movf = 1;
            if (acc && macc < CNT_MAX) macc++;
            if (drp && mdrp < CNT_MAX) mdrp++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_empty"}, int'(empty), 1);
        check({tag, "_full"}, int'(full), 0);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
`ifdef CAPTURE_STATS_EN
        check({tag, "_accepted"}, int'(accepted_cnt), 0);
        check({tag, "_dropped"}, int'(dropped_cnt), 0);
`endif
    endtask

    // Monitor: compares state each cycle and pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count", int'(count), mcnt);
            check("empty", int'(empty), int'(mcnt == 0));
            check("full", int'(full), int'(mcnt == DEPTH));
            check("in_ready", int'(in_ready), int'(mcnt != DEPTH));
            check("out_valid", int'(out_valid), int'(mcnt != 0));
            check("overflow", int'(overflow), movf);
`ifdef CAPTURE_STATS_EN
            check("accepted_cnt", int'(accepted_cnt), macc);
            check("dropped_cnt", int'(dropped_cnt), mdrp);
`endif
            if (!out_valid) begin
                check("out_data_idle", int'(out_data), 0);
            end else if (out_ready && !clear) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underrun", int'(out_data), -1);
                end else begin
                    automatic logic [WIDTH-1:0] e = exp_q.pop_front();
                    check("out_data", int'(out_data), int'(e));
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] seq3 [3];
        seq3[0] = 4'h3;
        seq3[1] = 4'hA;
        seq3[2] = 4'h5;

        // Reset state
        #2 check_reset_outputs("reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Order: three writes held, then three consecutive reads
        for (int i = 0; i < 3; i++) step(1'b1, seq3[i], 1'b0, 1'b0);
        check("order_count", int'(count), 3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("order_empty", int'(empty), 1);

        // Overflow: eight writes fill, ninth (0xF) dropped, drain returns eight
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i + 1), 1'b0, 1'b0);
        step(1'b1, 4'hF, 1'b0, 1'b0);
        check("ovf_full", int'(full), 1);
        check("ovf_in_ready", int'(in_ready), 0);
        check("ovf_flag", int'(overflow), 1);
`ifdef CAPTURE_STATS_EN
        check("ovf_accepted", int'(accepted_cnt), 8);
        check("ovf_dropped", int'(dropped_cnt), 1);
`endif

        // Full edge: simultaneous write and read while full
        step(1'b1, 4'hE, 1'b1, 1'b0);
        check("fulledge_count", int'(count), DEPTH - 1);
        check("fulledge_ovf", int'(overflow), 1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("drain_empty", int'(empty), 1);

        // Empty edge, then a 20-word stream across pointer wrap
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 4'h9, 1'b1, 1'b0);
        check("emptyedge_valid", int'(out_valid), 1);
        check("emptyedge_data", int'(out_data), 9);
        for (int i = 0; i < 20; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("stream_ovf", int'(overflow), 0);

        // Clear mid-stream at count 5
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        check("pre_clear_count", int'(count), 5);
        step(1'b1, 4'h7, 1'b1, 1'b1);
        check("clear_count", int'(count), 0);
        check("clear_valid", int'(out_valid), 0);

        // Async reset mid-cycle after refilling three words
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Randomized phases alternate write-heavy and read-heavy traffic with rare clears
        for (int p = 0; p < 12; p++) begin
            automatic int wp = (p % 2 == 0) ? 85 : 30;
            automatic int rp = (p % 2 == 0) ? 30 : 85;
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(99) < wp, WIDTH'($urandom), $urandom_range(99) < rp,
                     $urandom_range(299) == 0);
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("final_empty", int'(empty), 1);
        check("final_scoreboard", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
